// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared state encoding and default width for the serial subtractor
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/half_subtractor.sv
// half_subtractor: one-bit difference and borrow, the subtractive twin of the half adder
module half_subtractor (
    input  logic a,
    input  logic b,
    output logic d,
    output logic bo
);

    assign d  = a ^ b;
    assign bo = ~a & b;

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b, LSB first, with start/busy/done handshake
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   sh_a, sh_b, sh_d, d_next;
    logic               bff, a_msb, b_msb;
    logic               d1, b1, d, b2, bout;
    logic               accept, last;

    half_subtractor u_hs1 (.a(sh_a[0]), .b(sh_b[0]), .d(d1), .bo(b1));
    half_subtractor u_hs2 (.a(d1), .b(bff), .d(d), .bo(b2));

    assign bout   = b1 | b2;
    assign d_next = {d, sh_d[WIDTH-1:1]};
    assign last   = cnt == CNT_W'(WIDTH - 1);
    assign accept = start && (state == IDLE || state == DONE);

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next state: accept from IDLE or DONE, run WIDTH bit steps, then one DONE cycle
    always_comb begin
        state_next = state == IDLE ? (start ? RUN : IDLE) :
                     state == RUN  ? (last ? DONE : RUN) :
                     state == DONE ? (start ? RUN : IDLE) : IDLE;
    end

    // Handshake outputs decoded from the registered state only
    always_comb begin
        busy = state == RUN;
        done = state == DONE;
    end

    // Operand capture, per-bit shift datapath and result registers held until next completion
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_a       <= '0;
            sh_b       <= '0;
            sh_d       <= '0;
            bff        <= 1'b0;
            cnt        <= '0;
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
        end else if (accept) begin
            sh_a  <= a;
            sh_b  <= b;
            sh_d  <= '0;
            bff   <= 1'b0;
            cnt   <= '0;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
        end else if (state == RUN) begin
            sh_a <= sh_a >> 1;
            sh_b <= sh_b >> 1;
            sh_d <= d_next;
            bff  <= bout;
            cnt  <= cnt + CNT_W'(1);
            if (last) begin
                diff       <= d_next;
                borrow_out <= bout;
                overflow   <= (a_msb != b_msb) & (d != a_msb);
            end
        end
    end

endmodule
